// File: rtl/aes_pkg.sv
// Shared AES constants, scheduler FSM encoding and GF(2^8) helpers for the sbox tables.
package aes_pkg;

  localparam int AES_BYTE_W      = 8;
  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;

  localparam logic REQ_K = 1'b0;
  localparam logic REQ_S = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_S,
    BUSY_K,
    DONE_S,
    DONE_K
  } sched_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_rev(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward and inverse byte substitution lookups.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] result
);
  assign result = sbox_fwd(addr);
endmodule

module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] result
);
  assign result = sbox_rev(addr);
endmodule

// File: rtl/sbox_lane_bank.sv
// LANES parallel sbox lookups on flattened buses; inverse bank only when SBOX_INV_EN is defined.
module sbox_lane_bank
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES*AES_BYTE_W-1:0] addr,
`ifdef SBOX_INV_EN
  input  logic                        inv,
`endif
  output logic [LANES*AES_BYTE_W-1:0] result
);
  logic [LANES*AES_BYTE_W-1:0] fwd;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox u_sbox (
      .addr   (addr[j*AES_BYTE_W +: AES_BYTE_W]),
      .result (fwd[j*AES_BYTE_W +: AES_BYTE_W])
    );
  end

`ifdef SBOX_INV_EN
  logic [LANES*AES_BYTE_W-1:0] rev;

  for (genvar j = 0; j < LANES; j++) begin : g_inv_lane
    inv_sbox u_inv_sbox (
      .addr   (addr[j*AES_BYTE_W +: AES_BYTE_W]),
      .result (rev[j*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  assign result = inv ? rev : fwd;
`else
  assign result = fwd;
`endif

endmodule

// File: rtl/sbox_scheduler.sv
// Round-robin sharing of an sbox lane bank between cipher state (16 B) and key word (4 B) requests.
// Optional inverse-sbox path for state requests is enabled by defining SBOX_INV_EN.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_in_valid,
  output logic         s_in_ready,
  input  logic [127:0] s_in_data,
`ifdef SBOX_INV_EN
  input  logic         s_in_inv,
`endif
  output logic         s_out_valid,
  input  logic         s_out_ready,
  output logic [127:0] s_out_data,
  input  logic         k_in_valid,
  output logic         k_in_ready,
  input  logic [31:0]  k_in_data,
  output logic         k_out_valid,
  input  logic         k_out_ready,
  output logic [31:0]  k_out_data
);
  localparam int         LW    = LANES * AES_BYTE_W;
  localparam logic [4:0] LSTEP = 5'(LANES);

  sched_state_t  state, state_nxt;
  logic [127:0]  work;
  logic [127:0]  s_res;
  logic [31:0]   k_res;
  logic [4:0]    cnt;
  logic          rr_ptr;
  logic          inv_q;
  logic          grant_k, grant_s, last;
  logic [LW-1:0] lane_addr, lane_res;

  assign grant_k    = k_in_valid && (!s_in_valid || rr_ptr == REQ_K);
  assign grant_s    = s_in_valid && !grant_k;
  assign k_in_ready = (state == IDLE) && grant_k;
  assign s_in_ready = (state == IDLE) && grant_s;

  assign s_out_valid = (state == DONE_S);
  assign k_out_valid = (state == DONE_K);
  assign s_out_data  = s_res;
  assign k_out_data  = k_res;

  // The work register shifts left each busy cycle, so the lanes always see bytes cnt..cnt+LANES-1.
  assign lane_addr = work[127 -: LW];
  assign last      = (cnt + LSTEP) ==
                     ((state == BUSY_S) ? 5'(AES_STATE_BYTES) : 5'(AES_WORD_BYTES));

  sbox_lane_bank #(.LANES(LANES)) u_bank (
    .addr   (lane_addr),
`ifdef SBOX_INV_EN
    .inv    (inv_q && (state == BUSY_S)),
`endif
    .result (lane_res)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_k)      state_nxt = BUSY_K;
        else if (grant_s) state_nxt = BUSY_S;
      end
      BUSY_S:  if (last) state_nxt = DONE_S;
      BUSY_K:  if (last) state_nxt = DONE_K;
      DONE_S:  if (s_out_ready) state_nxt = IDLE;
      DONE_K:  if (k_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      s_res  <= '0;
      k_res  <= '0;
      cnt    <= '0;
      rr_ptr <= REQ_K;
      inv_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_k) begin
            work   <= {k_in_data, 96'd0};
            cnt    <= '0;
            rr_ptr <= REQ_S;
          end else if (grant_s) begin
            work   <= s_in_data;
            cnt    <= '0;
            rr_ptr <= REQ_K;
`ifdef SBOX_INV_EN
            inv_q  <= s_in_inv;
`else
            inv_q  <= 1'b0;
`endif
          end
        end
        // Results shift in at the bottom so byte order matches the input once all bytes are done.
        BUSY_S: begin
          work  <= work << LW;
          cnt   <= cnt + LSTEP;
          s_res <= (s_res << LW) | 128'(lane_res);
        end
        BUSY_K: begin
          work  <= work << LW;
          cnt   <= cnt + LSTEP;
          k_res <= (k_res << LW) | 32'(lane_res);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Scoreboard bench for sbox_scheduler: directed AES vectors, contention and mid-operation reset.
module tb_sbox_scheduler;
  localparam int LANES = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [127:0] s_in_data = '0;
  logic         s_in_inv = 1'b0;
  logic         s_out_valid;
  logic         s_out_ready = 1'b1;
  logic [127:0] s_out_data;
  logic         k_in_valid = 1'b0;
  logic         k_in_ready;
  logic [31:0]  k_in_data = '0;
  logic         k_out_valid;
  logic         k_out_ready = 1'b1;
  logic [31:0]  k_out_data;

  int tests = 0;
  int fails = 0;
  logic [127:0] sq[$];
  logic [31:0]  kq[$];

  always #5 clk = ~clk;

  sbox_scheduler #(.LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in_valid  (s_in_valid),
    .s_in_ready  (s_in_ready),
    .s_in_data   (s_in_data),
`ifdef SBOX_INV_EN
    .s_in_inv    (s_in_inv),
`endif
    .s_out_valid (s_out_valid),
    .s_out_ready (s_out_ready),
    .s_out_data  (s_out_data),
    .k_in_valid  (k_in_valid),
    .k_in_ready  (k_in_ready),
    .k_in_data   (k_in_data),
    .k_out_valid (k_out_valid),
    .k_out_ready (k_out_ready),
    .k_out_data  (k_out_data)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare whenever an output handshake is about to happen.
  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (sq.size() == 0) begin
        tests++; fails++;
        $display("FAIL s_out_unexpected: got %h, expected no output", s_out_data);
      end else begin
        logic [127:0] e;
        e = sq.pop_front();
        chk("s_out_data", s_out_data, e);
      end
    end
    if (rst_n && k_out_valid && k_out_ready) begin
      if (kq.size() == 0) begin
        tests++; fails++;
        $display("FAIL k_out_unexpected: got %h, expected no output", k_out_data);
      end else begin
        logic [31:0] e;
        e = kq.pop_front();
        chk("k_out_data", 128'(k_out_data), 128'(e));
      end
    end
  end

  // Issue one state request, check latency, let the monitor check data on the handshake.
  task automatic run_s(input logic [127:0] d, input logic [127:0] e, input logic inv);
    int n;
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_in_data = d; s_in_inv = inv;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_in_ready && n < 100);
    chk("s_in_ready_seen", 128'(s_in_ready), 128'(1));
    sq.push_back(e);
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_in_data = {4{32'hdeadbeef}}; s_in_inv = 1'b0;
    n = 0;
    while (!s_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("s_latency", 128'(n), 128'(16 / LANES));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_s_out_valid", 128'(s_out_valid), 128'(0));
    chk("rst_k_out_valid", 128'(k_out_valid), 128'(0));
    chk("rst_s_out_data", s_out_data, 128'(0));
    chk("rst_k_out_data", 128'(k_out_data), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single key word with consumer back-pressure.
    k_out_ready = 1'b0;
    k_in_valid = 1'b1; k_in_data = 32'hcf4f3c09;
    n = 0;
    do begin @(negedge clk); n++; end while (!k_in_ready && n < 100);
    chk("k_in_ready_seen", 128'(k_in_ready), 128'(1));
    kq.push_back(32'h8a84eb01);
    @(posedge clk); #1;
    k_in_valid = 1'b0; k_in_data = 32'h0;
    n = 0;
    while (!k_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("k_latency", 128'(n), 128'(4 / LANES));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("k_hold_valid", 128'(k_out_valid), 128'(1));
      chk("k_hold_data", 128'(k_out_data), 128'(32'h8a84eb01));
    end
    k_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("k_valid_drop", 128'(k_out_valid), 128'(0));
    chk("k_data_kept", 128'(k_out_data), 128'(32'h8a84eb01));

    // State substitutions.
    run_s(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
    run_s(128'h19452901efa47b33_00000000_00000000, 128'hd46ea57cdf4921c3_63636363_63636363, 1'b0);

    // Contention: reset release restores key priority.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    k_in_valid = 1'b1; k_in_data = 32'h00015300;
    s_in_valid = 1'b1; s_in_data = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(negedge clk);
    chk("cont_k_ready", 128'(k_in_ready), 128'(1));
    chk("cont_s_ready", 128'(s_in_ready), 128'(0));
    kq.push_back(32'h637ced63);
    @(posedge clk); #1;
    k_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 100) begin
      chk("cont_busy_k_ready", 128'(k_in_ready), 128'(0));
      @(negedge clk); n++;
    end
    chk("cont_s_granted", 128'(s_in_ready), 128'(1));
    sq.push_back(128'hd42711aee0bf98f1b8b45de51e415230);
    @(posedge clk); #1;
    k_in_valid = 1'b1; k_in_data = 32'hcf4f3c09;
    n = 0;
    @(negedge clk);
    while (!k_in_ready && !s_in_ready && n < 100) begin @(negedge clk); n++; end
    chk("cont_k_again", 128'(k_in_ready), 128'(1));
    chk("cont_s_blocked", 128'(s_in_ready), 128'(0));
    kq.push_back(32'h8a84eb01);
    @(posedge clk); #1;
    k_in_valid = 1'b0; s_in_valid = 1'b0;
    n = 0;
    while ((kq.size() != 0 || k_out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    chk("cont_drained", 128'(kq.size()), 128'(0));

    // Reset in the second busy cycle of a state request.
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_in_data = 128'h0102030405060708090a0b0c0d0e0f10;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_in_ready && n < 100);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_s_out_valid", 128'(s_out_valid), 128'(0));
    chk("mid_rst_s_out_data", s_out_data, 128'(0));
    chk("mid_rst_k_out_data", 128'(k_out_data), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (s_out_valid) n++; end
    chk("no_stale_s_valid", 128'(n), 128'(0));
    run_s(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);

`ifdef SBOX_INV_EN
    run_s(128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1);
`endif

    repeat (3) @(posedge clk);
    chk("sq_empty", 128'(sq.size()), 128'(0));
    chk("kq_empty", 128'(kq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
